// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: ALU op codes, opcode/funct encodings and the
// decode-result and ID/EX register structs.
package mips_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_BGEZ = 5'd9;
    localparam logic [4:0] ALU_BLEZ = 5'd10;
    localparam logic [4:0] ALU_BGTZ = 5'd11;
    localparam logic [4:0] ALU_LUI  = 5'd12;
    localparam logic [4:0] ALU_SLTU = 5'd13;
    localparam logic [4:0] ALU_SLT  = 5'd14;
    localparam logic [4:0] ALU_SLLV = 5'd15;
    localparam logic [4:0] ALU_SRLV = 5'd16;
    localparam logic [4:0] ALU_SRAV = 5'd17;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic       {D0_RS, D0_SHAMT} d0_sel_e;
    typedef enum logic [2:0] {D1_RT, D1_SEXT, D1_ZEXT, D1_ONE, D1_ZERO} d1_sel_e;
    typedef enum logic       {DST_RD, DST_RT} dst_sel_e;

    typedef struct packed {
        logic [4:0] op;
        d0_sel_e    d0_sel;
        d1_sel_e    d1_sel;
        logic       we;
        dst_sel_e   dst;
        logic       branch;
        logic       illegal;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [4:0]  rd;
        logic        we;
        logic        branch;
        logic        illegal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        d0_reg;
        logic        d1_reg;
    } ex_reg_t;

endpackage

// File: rtl/id_decode.sv
// Combinational MIPS decoder: instruction word to ALU op, operand sources,
// destination select and branch/illegal flags.
module id_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] opcode, funct;
    logic [4:0] rt;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];

    always_comb begin
        dec = '{op: ALU_ADD, d0_sel: D0_RS, d1_sel: D1_RT, we: 1'b0,
                dst: DST_RD, branch: 1'b0, illegal: 1'b0};
        case (opcode)
            OP_RTYPE: begin
                dec.we = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: dec.op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.op = ALU_SUB;
                    FN_AND:  dec.op = ALU_AND;
                    FN_OR:   dec.op = ALU_OR;
                    FN_XOR:  dec.op = ALU_XOR;
                    FN_NOR:  dec.op = ALU_NOR;
                    FN_SLT:  dec.op = ALU_SLT;
                    FN_SLTU: dec.op = ALU_SLTU;
                    FN_SLL:  begin dec.op = ALU_SLL; dec.d0_sel = D0_SHAMT; end
                    FN_SRL:  begin dec.op = ALU_SRL; dec.d0_sel = D0_SHAMT; end
                    FN_SRA:  begin dec.op = ALU_SRA; dec.d0_sel = D0_SHAMT; end
                    FN_SLLV: dec.op = ALU_SLLV;
                    FN_SRLV: dec.op = ALU_SRLV;
                    FN_SRAV: dec.op = ALU_SRAV;
                    default: begin dec.we = 1'b0; dec.illegal = 1'b1; end
                endcase
            end
            // rt selects bgez (1) / bltz (0); EX compares rs against d1
            OP_REGIMM: begin
                if (rt == 5'd0 || rt == 5'd1) begin
                    dec.op     = ALU_BGEZ;
                    dec.d1_sel = (rt == 5'd1) ? D1_ONE : D1_ZERO;
                    dec.branch = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_BEQ, OP_BNE: begin dec.op = ALU_SUB; dec.branch = 1'b1; end
            OP_BLEZ: begin dec.op = ALU_BLEZ; dec.d1_sel = D1_ZERO; dec.branch = 1'b1; end
            OP_BGTZ: begin dec.op = ALU_BGTZ; dec.d1_sel = D1_ZERO; dec.branch = 1'b1; end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                dec.d1_sel = D1_SEXT; dec.we = 1'b1; dec.dst = DST_RT;
            end
            OP_SW:    dec.d1_sel = D1_SEXT;
            OP_SLTI:  begin dec.op = ALU_SLT;  dec.d1_sel = D1_SEXT; dec.we = 1'b1; dec.dst = DST_RT; end
            OP_SLTIU: begin dec.op = ALU_SLTU; dec.d1_sel = D1_SEXT; dec.we = 1'b1; dec.dst = DST_RT; end
            OP_ANDI:  begin dec.op = ALU_AND;  dec.d1_sel = D1_ZEXT; dec.we = 1'b1; dec.dst = DST_RT; end
            OP_ORI:   begin dec.op = ALU_OR;   dec.d1_sel = D1_ZEXT; dec.we = 1'b1; dec.dst = DST_RT; end
            OP_XORI:  begin dec.op = ALU_XOR;  dec.d1_sel = D1_ZEXT; dec.we = 1'b1; dec.dst = DST_RT; end
            OP_LUI:   begin dec.op = ALU_LUI;  dec.d1_sel = D1_ZEXT; dec.we = 1'b1; dec.dst = DST_RT; end
            default:  dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decode, MEM/WB operand forwarding, and a register
// with flush > stall > load priority plus WB refresh of held operands.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_we_i,
    input  logic [4:0]  mem_rd_i,
    input  logic [31:0] mem_data_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        valid_o,
    output logic [4:0]  alu_op_o,
    output logic [31:0] d0_o,
    output logic [31:0] d1_o,
    output logic [4:0]  rd_o,
    output logic        reg_we_o,
    output logic        is_branch_o,
    output logic        illegal_o
);

    dec_t        dec;
    ex_reg_t     q, nxt;
    logic [4:0]  rs_idx, rt_idx;
    logic [31:0] rs_fwd, rt_fwd, sext, zext;

    id_decode u_dec (.instr(instr_i), .dec(dec));

    assign rs_idx = instr_i[25:21];
    assign rt_idx = instr_i[20:16];
    assign sext   = {{16{instr_i[15]}}, instr_i[15:0]};
    assign zext   = {16'h0, instr_i[15:0]};

    // MEM is younger than WB, so it wins when both target the same register
    assign rs_fwd = (FWD_EN && mem_we_i && rs_idx != 5'd0 && mem_rd_i == rs_idx) ? mem_data_i :
                    (FWD_EN && wb_we_i  && rs_idx != 5'd0 && wb_rd_i  == rs_idx) ? wb_data_i  :
                    rs_data_i;
    assign rt_fwd = (FWD_EN && mem_we_i && rt_idx != 5'd0 && mem_rd_i == rt_idx) ? mem_data_i :
                    (FWD_EN && wb_we_i  && rt_idx != 5'd0 && wb_rd_i  == rt_idx) ? wb_data_i  :
                    rt_data_i;

    always_comb begin
        nxt = '0;
        if (valid_i) begin
            nxt.valid   = 1'b1;
            nxt.op      = dec.op;
            nxt.we      = dec.we;
            nxt.branch  = dec.branch;
            nxt.illegal = dec.illegal;
            nxt.rs      = rs_idx;
            nxt.rt      = rt_idx;
            nxt.d0_reg  = (dec.d0_sel == D0_RS);
            nxt.d1_reg  = (dec.d1_sel == D1_RT);
            nxt.d0      = (dec.d0_sel == D0_SHAMT) ? {27'h0, instr_i[10:6]} : rs_fwd;
            case (dec.d1_sel)
                D1_SEXT: nxt.d1 = sext;
                D1_ZEXT: nxt.d1 = zext;
                D1_ONE:  nxt.d1 = 32'd1;
                D1_ZERO: nxt.d1 = 32'd0;
                default: nxt.d1 = rt_fwd;
            endcase
            if (dec.we)
                nxt.rd = (dec.dst == DST_RD) ? instr_i[15:11] : rt_idx;
        end
    end

    // A held instruction must still see results that retire while it waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush_i) begin
            q <= '0;
        end else if (stall_i) begin
            if (wb_we_i && q.d0_reg && q.rs != 5'd0 && wb_rd_i == q.rs)
                q.d0 <= wb_data_i;
            if (wb_we_i && q.d1_reg && q.rt != 5'd0 && wb_rd_i == q.rt)
                q.d1 <= wb_data_i;
        end else begin
            q <= nxt;
        end
    end

    assign valid_o     = q.valid;
    assign alu_op_o    = q.op;
    assign d0_o        = q.d0;
    assign d1_o        = q.d1;
    assign rd_o        = q.rd;
    assign reg_we_o    = q.we;
    assign is_branch_o = q.branch;
    assign illegal_o   = q.illegal;

endmodule
